fb_scaler_reader: RTL and testbench



---
 rtl/fb_scaler_reader.sv | 183 ++++++++++++++++++
 tb/tb_fb_scaler_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scaler_reader.sv
// Frame-buffer read engine and scaler. It maps display coordinates to
// source pixels in one of four modes and produces RGB three cycles later.
module fb_scaler_reader #(
  parameter int SRC_W   = 320,
  parameter int SRC_H   = 240,
  parameter int DST_W   = 640,
  parameter int DST_H   = 480,
  parameter int CH_BITS = 4,
  parameter int ADDR_W  = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   display_en,
  input  logic [9:0]             x_coor,
  input  logic [9:0]             y_coor,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [3*CH_BITS-1:0]   rd_data,
  output logic                   pix_valid,
  output logic [CH_BITS-1:0]     red,
  output logic [CH_BITS-1:0]     green,
  output logic [CH_BITS-1:0]     blue
);

  localparam int PW = 3 * CH_BITS;

  localparam logic [9:0] SW     = 10'(SRC_W);
  localparam logic [9:0] SW_M1  = 10'(SRC_W - 1);
  localparam logic [9:0] DW     = 10'(DST_W);
  localparam logic [9:0] DH     = 10'(DST_H);
  localparam logic [9:0] OX     = 10'((DST_W - SRC_W) / 2);
  localparam logic [9:0] OY     = 10'((DST_H - SRC_H) / 2);
  localparam logic [9:0] OX_END = 10'((DST_W - SRC_W) / 2 + SRC_W);
  localparam logic [9:0] OY_END = 10'((DST_H - SRC_H) / 2 + SRC_H);
  localparam logic [9:0] BAR_W  = 10'(DST_W / 8);

  typedef enum logic [1:0] {
    MODE_WIN   = 2'd0,
    MODE_NEAR  = 2'd1,
    MODE_BILIN = 2'd2,
    MODE_BARS  = 2'd3
  } mode_t;

  // How the output stage builds the pixel once the read data is back.
  typedef enum logic [1:0] {
    PX_BLACK,
    PX_MEM,
    PX_AVG,
    PX_BAR
  } px_t;

  mode_t           mode_q, mode_cur;
  logic            frame_start, act, in_win;
  logic [9:0]      sx, sy, nx;
  logic            rd_req;
  px_t             kind0, kind1, kind2;
  logic [2:0]      bar0, bar1, bar2;
  logic [2:0]      bar_idx;
  logic            v1, v2;
  logic [PW-1:0]   hold, pix;

  // Frame mode: the (0,0) pixel already uses the newly sampled mode.
  always_comb begin
    frame_start = (x_coor == '0) && (y_coor == '0);
    mode_cur    = frame_start ? mode_t'(mode) : mode_q;
  end

  // Mode register, updated once per frame.
  always_ff @(posedge clk) begin
    if (reset)            mode_q <= MODE_NEAR;
    else if (frame_start) mode_q <= mode_t'(mode);
  end

  // Stage 0: coordinate mapping, read request and pixel source selection.
  always_comb begin
    act     = display_en && (x_coor < DW) && (y_coor < DH);
    in_win  = act && (x_coor >= OX) && (x_coor < OX_END) &&
              (y_coor >= OY) && (y_coor < OY_END);
    sx      = '0;
    sy      = '0;
    nx      = (x_coor >> 1) + 10'd1;
    rd_req  = 1'b0;
    kind0   = PX_BLACK;
    bar_idx = 3'(x_coor / BAR_W);
    bar0    = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]};
    unique case (mode_cur)
      MODE_WIN: begin
        sx = x_coor - OX;
        sy = y_coor - OY;
        if (in_win) begin
          rd_req = 1'b1;
          kind0  = PX_MEM;
        end
      end
      MODE_NEAR: begin
        sx     = x_coor >> 1;
        sy     = y_coor >> 1;
        rd_req = act;
        if (act) kind0 = PX_MEM;
      end
      MODE_BILIN: begin
        sy     = y_coor >> 1;
        rd_req = act;
        if (x_coor[0]) begin
          sx = (nx > SW_M1) ? SW_M1 : nx;
          if (act) kind0 = PX_AVG;
        end else begin
          sx = x_coor >> 1;
          if (act) kind0 = PX_MEM;
        end
      end
      MODE_BARS: begin
        if (act) kind0 = PX_BAR;
      end
      default: ;
    endcase
  end

  // Stage 1: registered read request plus pixel control.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      v1      <= 1'b0;
      kind1   <= PX_BLACK;
      bar1    <= '0;
    end else begin
      rd_en   <= rd_req;
      rd_addr <= ADDR_W'(32'(sy) * 32'(SW) + 32'(sx));
      v1      <= act;
      kind1   <= kind0;
      bar1    <= bar0;
    end
  end

  // Stage 2: control waits for the frame-buffer read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2    <= 1'b0;
      kind2 <= PX_BLACK;
      bar2  <= '0;
    end else begin
      v2    <= v1;
      kind2 <= kind1;
      bar2  <= bar1;
    end
  end

  // Output pixel assembly from read data, hold register or bar colour.
  always_comb begin
    pix = '0;
    unique case (kind2)
      PX_MEM: pix = rd_data;
      PX_AVG: begin
        for (int unsigned c = 0; c < 3; c++) begin
          pix[c*CH_BITS +: CH_BITS] = CH_BITS'(({1'b0, hold[c*CH_BITS +: CH_BITS]} +
                                               {1'b0, rd_data[c*CH_BITS +: CH_BITS]}) >> 1);
        end
      end
      PX_BAR: pix = {{CH_BITS{bar2[2]}}, {CH_BITS{bar2[1]}}, {CH_BITS{bar2[0]}}};
      default: pix = '0;
    endcase
  end

  // Stage 3: registered outputs; even bilinear pixels are kept for the odd neighbour.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      hold      <= '0;
    end else begin
      pix_valid <= v2;
      red       <= pix[PW-1 -: CH_BITS];
      green     <= pix[2*CH_BITS-1 -: CH_BITS];
      blue      <= pix[CH_BITS-1:0];
      if (kind2 == PX_MEM) hold <= rd_data;
    end
  end

endmodule

// File: tb/tb_fb_scaler_reader.sv
// Directed bench for fb_scaler_reader with a synchronous frame-buffer model.
module tb_fb_scaler_reader;

  localparam int AW = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd1;
  logic        display_en = 1'b0;
  logic [9:0]  x_coor = 10'd0;
  logic [9:0]  y_coor = 10'd0;
  logic        rd_en;
  logic [AW-1:0] rd_addr;
  logic [11:0] rd_data = 12'd0;
  logic        pix_valid;
  logic [3:0]  red, green, blue;

  int checks = 0;
  int errors = 0;
  int n = 0;

  logic [11:0]   mem [0:131071];
  logic          obs_en   [0:1023];
  logic [AW-1:0] obs_addr [0:1023];
  logic [11:0]   obs_rgb  [0:1023];
  logic          obs_pv   [0:1023];

  fb_scaler_reader #(
    .SRC_W(320), .SRC_H(240), .DST_W(640), .DST_H(480), .CH_BITS(4), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .display_en(display_en),
    .x_coor(x_coor), .y_coor(y_coor), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .pix_valid(pix_valid), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // Synchronous frame buffer: data one cycle after the address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  function automatic logic [11:0] pat(input int i);
    return 12'(i * 37 + 5);
  endfunction

  // Apply one coordinate, advance one clock, record outputs #1 after the edge.
  // A coordinate applied at index k shows rd_* at k and RGB at k+2.
  task automatic cyc(input logic de, input int x, input int y);
    display_en = de;
    x_coor = 10'(x);
    y_coor = 10'(y);
    @(posedge clk);
    #1;
    if (n < 1024) begin
      obs_en[n]   = rd_en;
      obs_addr[n] = rd_addr;
      obs_rgb[n]  = {red, green, blue};
      obs_pv[n]   = pix_valid;
      n++;
    end
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) cyc(1'b0, 700, 5);
  endtask

  task automatic test_reset;
    int k;
    reset = 1'b1;
    mode = 2'd1;
    repeat (4) cyc(1'b1, 10, 10);
    k = n - 1;
    checks++; if (obs_en[k] !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", obs_en[k]); end
    checks++; if (obs_addr[k] !== '0) begin errors++; $display("FAIL reset_rd_addr got %0d exp 0", obs_addr[k]); end
    checks++; if (obs_pv[k] !== 1'b0 || obs_rgb[k] !== 12'h000) begin errors++; $display("FAIL reset_out got pv=%b rgb=%h exp pv=0 rgb=000", obs_pv[k], obs_rgb[k]); end
    reset = 1'b0;
    idle(4);
    k = n - 1;
    checks++; if (obs_en[k] !== 1'b0 || obs_pv[k] !== 1'b0 || obs_rgb[k] !== 12'h000) begin
      errors++; $display("FAIL idle_out got en=%b pv=%b rgb=%h exp 0/0/000", obs_en[k], obs_pv[k], obs_rgb[k]);
    end
    // Mode input changes without passing (0,0): reset mode (2x nearest) stays.
    mode = 2'd2;
    k = n;
    cyc(1'b1, 5, 3);
    idle(3);
    checks++; if (obs_en[k] !== 1'b1 || obs_addr[k] !== 17'd322) begin
      errors++; $display("FAIL first_frame_mode got en=%b addr=%0d exp en=1 addr=322", obs_en[k], obs_addr[k]);
    end
  endtask

  task automatic test_nearest;
    int k;
    mode = 2'd1;
    cyc(1'b1, 0, 0);
    k = n;
    cyc(1'b1, 5, 3);
    idle(3);
    checks++; if (obs_en[k] !== 1'b1 || obs_addr[k] !== 17'd322) begin
      errors++; $display("FAIL nearest_addr got en=%b addr=%0d exp en=1 addr=322", obs_en[k], obs_addr[k]);
    end
    checks++; if (obs_rgb[k+1] !== 12'h123 || obs_pv[k+1] !== 1'b1) begin
      errors++; $display("FAIL nearest_origin got rgb=%h pv=%b exp 123/1", obs_rgb[k+1], obs_pv[k+1]);
    end
    checks++; if (obs_rgb[k+2] !== 12'hA5C || obs_pv[k+2] !== 1'b1) begin
      errors++; $display("FAIL nearest_pix got rgb=%h pv=%b exp A5C/1", obs_rgb[k+2], obs_pv[k+2]);
    end
    checks++; if (obs_en[k+1] !== 1'b0 || obs_rgb[k+3] !== 12'h000 || obs_pv[k+3] !== 1'b0) begin
      errors++; $display("FAIL inactive got en=%b rgb=%h pv=%b exp 0/000/0", obs_en[k+1], obs_rgb[k+3], obs_pv[k+3]);
    end
  endtask

  task automatic test_bilinear;
    int k;
    mode = 2'd2;
    cyc(1'b1, 0, 0);
    k = n;
    cyc(1'b1, 2, 0);
    cyc(1'b1, 3, 0);
    cyc(1'b1, 638, 0);
    cyc(1'b1, 639, 0);
    idle(3);
    checks++; if (obs_addr[k] !== 17'd1 || obs_addr[k+1] !== 17'd2) begin
      errors++; $display("FAIL bilin_addr got %0d,%0d exp 1,2", obs_addr[k], obs_addr[k+1]);
    end
    checks++; if (obs_rgb[k+2] !== 12'hF00) begin errors++; $display("FAIL bilin_even got %h exp F00", obs_rgb[k+2]); end
    checks++; if (obs_rgb[k+3] !== 12'h770) begin errors++; $display("FAIL bilin_odd got %h exp 770", obs_rgb[k+3]); end
    checks++; if (obs_en[k+3] !== 1'b1 || obs_addr[k+3] !== 17'd319 || obs_addr[k+2] !== 17'd319) begin
      errors++; $display("FAIL bilin_edge_addr got en=%b addr=%0d/%0d exp 1 319/319", obs_en[k+3], obs_addr[k+2], obs_addr[k+3]);
    end
    checks++; if (obs_rgb[k+5] !== 12'h3C7 || obs_pv[k+5] !== 1'b1) begin
      errors++; $display("FAIL bilin_edge_pix got rgb=%h pv=%b exp 3C7/1", obs_rgb[k+5], obs_pv[k+5]);
    end
  endtask

  task automatic test_window;
    int k;
    mode = 2'd0;
    cyc(1'b1, 0, 0);
    k = n;
    cyc(1'b1, 160, 120);
    cyc(1'b1, 159, 120);
    cyc(1'b1, 479, 359);
    idle(3);
    checks++; if (obs_rgb[k+1] !== 12'h000 || obs_pv[k+1] !== 1'b1) begin
      errors++; $display("FAIL win_border_origin got rgb=%h pv=%b exp 000/1", obs_rgb[k+1], obs_pv[k+1]);
    end
    checks++; if (obs_en[k] !== 1'b1 || obs_addr[k] !== 17'd0) begin
      errors++; $display("FAIL win_corner_addr got en=%b addr=%0d exp 1/0", obs_en[k], obs_addr[k]);
    end
    checks++; if (obs_rgb[k+2] !== 12'h123) begin errors++; $display("FAIL win_corner_pix got %h exp 123", obs_rgb[k+2]); end
    checks++; if (obs_en[k+1] !== 1'b0 || obs_rgb[k+3] !== 12'h000 || obs_pv[k+3] !== 1'b1) begin
      errors++; $display("FAIL win_outside got en=%b rgb=%h pv=%b exp 0/000/1", obs_en[k+1], obs_rgb[k+3], obs_pv[k+3]);
    end
    checks++; if (obs_en[k+2] !== 1'b1 || obs_addr[k+2] !== 17'd76799) begin
      errors++; $display("FAIL win_last_addr got en=%b addr=%0d exp 1/76799", obs_en[k+2], obs_addr[k+2]);
    end
    checks++; if (obs_rgb[k+4] !== 12'h9AB) begin errors++; $display("FAIL win_last_pix got %h exp 9AB", obs_rgb[k+4]); end
  endtask

  task automatic test_bars;
    int k;
    logic [11:0] exp_rgb [0:3];
    exp_rgb[0] = 12'hFFF; exp_rgb[1] = 12'hFF0; exp_rgb[2] = 12'hF0F; exp_rgb[3] = 12'h000;
    mode = 2'd3;
    k = n;
    cyc(1'b1, 0, 0);
    cyc(1'b1, 85, 0);
    cyc(1'b1, 320, 0);
    cyc(1'b1, 639, 0);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_rgb[k+2+i] !== exp_rgb[i] || obs_pv[k+2+i] !== 1'b1 || obs_en[k+i] !== 1'b0) begin
        errors++;
        $display("FAIL bars_%0d got rgb=%h pv=%b en=%b exp %h/1/0", i, obs_rgb[k+2+i], obs_pv[k+2+i], obs_en[k+i], exp_rgb[i]);
      end
    end
  endtask

  task automatic test_mode_change;
    int k;
    mode = 2'd1;
    cyc(1'b1, 0, 0);
    cyc(1'b1, 99, 10);
    mode = 2'd2;
    k = n;
    cyc(1'b1, 100, 10);
    cyc(1'b1, 101, 10);
    checks++; if (obs_addr[k+1] !== 17'd1650) begin
      errors++; $display("FAIL midframe_mode got addr=%0d exp 1650", obs_addr[k+1]);
    end
    cyc(1'b1, 0, 0);
    k = n;
    cyc(1'b1, 1, 0);
    idle(3);
    checks++; if (obs_addr[k] !== 17'd1) begin errors++; $display("FAIL next_frame_addr got %0d exp 1", obs_addr[k]); end
    checks++; if (obs_rgb[k+2] !== 12'h811) begin errors++; $display("FAIL next_frame_avg got %h exp 811", obs_rgb[k+2]); end
  endtask

  task automatic test_reset_midline;
    int k;
    cyc(1'b1, 48, 20);
    cyc(1'b1, 49, 20);
    reset = 1'b1;
    k = n;
    cyc(1'b1, 50, 20);
    checks++; if (obs_pv[k] !== 1'b0 || obs_rgb[k] !== 12'h000 || obs_en[k] !== 1'b0) begin
      errors++; $display("FAIL midline_reset got pv=%b rgb=%h en=%b exp 0/000/0", obs_pv[k], obs_rgb[k], obs_en[k]);
    end
    reset = 1'b0;
    k = n;
    cyc(1'b1, 51, 20);
    cyc(1'b1, 52, 20);
    idle(3);
    checks++; if (obs_addr[k] !== 17'd3225 || obs_addr[k+1] !== 17'd3226) begin
      errors++; $display("FAIL resume_addr got %0d,%0d exp 3225,3226", obs_addr[k], obs_addr[k+1]);
    end
    checks++; if (obs_pv[k+1] !== 1'b0) begin errors++; $display("FAIL resume_flushed got pv=%b exp 0", obs_pv[k+1]); end
    checks++; if (obs_rgb[k+2] !== mem[3225] || obs_pv[k+2] !== 1'b1) begin
      errors++; $display("FAIL resume_pix0 got rgb=%h pv=%b exp %h/1", obs_rgb[k+2], obs_pv[k+2], mem[3225]);
    end
    checks++; if (obs_rgb[k+3] !== mem[3226]) begin
      errors++; $display("FAIL resume_pix1 got %h exp %h", obs_rgb[k+3], mem[3226]);
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = pat(i);
    mem[0] = 12'h123;
    mem[1] = 12'hF00;
    mem[2] = 12'h0F0;
    mem[319] = 12'h3C7;
    mem[322] = 12'hA5C;
    mem[76799] = 12'h9AB;
    test_reset();
    test_nearest();
    test_bilinear();
    test_window();
    test_bars();
    test_mode_change();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
